// File: rtl/interrupt_sequencer_if.sv
// Interrupt sequencer bus bundle.
// Request lines, config port and PC override.
interface interrupt_sequencer_if;
   logic [7:0]  irq_in;
   logic [15:0] pc_in;
   logic        end_routine;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] cfg_rdata;
   logic        pc_override;
   logic [15:0] pc_addr;
   logic        in_service;
   logic [2:0]  irq_id;

   modport master (
      output irq_in, pc_in, end_routine,
      output cfg_we, cfg_addr, cfg_wdata,
      input  cfg_rdata, pc_override, pc_addr,
      input  in_service, irq_id
   );

   modport slave (
      input  irq_in, pc_in, end_routine,
      input  cfg_we, cfg_addr, cfg_wdata,
      output cfg_rdata, pc_override, pc_addr,
      output in_service, irq_id
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// Edge-triggered interrupt sequencer.
// Vectors to VEC_BASE+4*id, returns via RET.
module interrupt_sequencer #(
   parameter int          N_IRQ    = 8,
   parameter logic [15:0] VEC_BASE = 16'h0300
) (
   input logic                 clk,
   input logic                 rst,
   interrupt_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTER,
      S_SERVICE,
      S_RETURN
   } state_t;

   state_t state_q, state_d;

   logic [N_IRQ-1:0] ier_q;
   logic [N_IRQ-1:0] ifr_q;
   logic [N_IRQ-1:0] prev_q;
   logic [N_IRQ-1:0] arm_q;
   logic             gie_q;
   logic [15:0]      ret_q;
   logic [2:0]       id_q, id_d;

   logic [N_IRQ-1:0] edge_det;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] w1c;
   logic [N_IRQ-1:0] enter_clr;
   logic [2:0]       prio;
   logic             ret_ld;
   logic             pc_ovr;
   logic [15:0]      pc_tgt;
   logic             in_svc;
   logic             unused_ok;

   // A line counts only once seen low since reset.
   assign edge_det = bus.irq_in & ~prev_q & arm_q;
   assign pending  = ifr_q & ier_q;

   assign w1c = (bus.cfg_we && bus.cfg_addr == 2'd1)
              ? bus.cfg_wdata[N_IRQ-1:0] : '0;

   assign unused_ok = ^bus.cfg_wdata[15:N_IRQ];

   // Lowest pending index wins.
   always_comb begin
      prio = 3'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) prio = i[2:0];
      end
   end

   // Next state and per-state outputs.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      pc_ovr    = 1'b0;
      pc_tgt    = 16'h0000;
      in_svc    = 1'b0;
      enter_clr = '0;
      ret_ld    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (gie_q && |pending) begin
               id_d    = prio;
               state_d = S_ENTER;
            end
         end
         S_ENTER: begin
            pc_ovr        = 1'b1;
            pc_tgt        = VEC_BASE + {11'd0, id_q, 2'b00};
            ret_ld        = 1'b1;
            enter_clr[id_q] = 1'b1;
            state_d       = S_SERVICE;
         end
         S_SERVICE: begin
            in_svc = 1'b1;
            if (bus.end_routine) state_d = S_RETURN;
         end
         S_RETURN: begin
            pc_ovr  = 1'b1;
            pc_tgt  = ret_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and serviced id.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         id_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
      end
   end

   // Edge detect; flag set beats any clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= '0;
         arm_q  <= '0;
         ifr_q  <= '0;
      end else begin
         prev_q <= bus.irq_in;
         arm_q  <= arm_q | ~bus.irq_in;
         ifr_q  <= (ifr_q & ~(w1c | enter_clr)) | edge_det;
      end
   end

   // Config registers and return address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ier_q <= '0;
         gie_q <= 1'b0;
         ret_q <= 16'h0000;
      end else begin
         if (bus.cfg_we && bus.cfg_addr == 2'd0)
            ier_q <= bus.cfg_wdata[N_IRQ-1:0];
         if (bus.cfg_we && bus.cfg_addr == 2'd2)
            gie_q <= bus.cfg_wdata[0];
         if (ret_ld)
            ret_q <= bus.pc_in;
      end
   end

   // Combinational register readback.
   always_comb begin
      bus.cfg_rdata = 16'h0000;
      unique case (bus.cfg_addr)
         2'd0: bus.cfg_rdata = {8'h00, ier_q};
         2'd1: bus.cfg_rdata = {8'h00, ifr_q};
         2'd2: bus.cfg_rdata = {14'd0, in_svc, gie_q};
         2'd3: bus.cfg_rdata = ret_q;
         default: bus.cfg_rdata = 16'h0000;
      endcase
   end

   assign bus.pc_override = pc_ovr;
   assign bus.pc_addr     = pc_tgt;
   assign bus.in_service  = in_svc;
   assign bus.irq_id      = id_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_interrupt_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   interrupt_sequencer_if bus ();

   interrupt_sequencer #(
      .N_IRQ    (8),
      .VEC_BASE (16'h0300)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [15:0] obs,
                        input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag,
                     input logic [1:0] a,
                     input logic [15:0] exp);
      bus.cfg_addr = a;
      #1;
      check(tag, bus.cfg_rdata, exp);
   endtask

   task automatic wr(input logic [1:0] a,
                     input logic [15:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick;
      bus.cfg_we    = 1'b0;
   endtask

   task automatic end_pulse;
      bus.end_routine = 1'b1;
      tick;
      bus.end_routine = 1'b0;
      #1;
   endtask

   initial begin
      bus.irq_in      = 8'h00;
      bus.pc_in       = 16'h0000;
      bus.end_routine = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_addr    = 2'd0;
      bus.cfg_wdata   = 16'h0000;

      // reset state
      tick;
      tick;
      rd("rst_ier", 2'd0, 16'h0000);
      rd("rst_ifr", 2'd1, 16'h0000);
      rd("rst_ctrl", 2'd2, 16'h0000);
      rd("rst_ret", 2'd3, 16'h0000);
      check("rst_ovr", {15'd0, bus.pc_override}, 16'h0000);
      check("rst_isvc", {15'd0, bus.in_service}, 16'h0000);
      check("rst_id", {13'd0, bus.irq_id}, 16'h0000);
      rst = 1'b1;
      tick;
      tick;

      // single irq 0 entry and return
      wr(2'd0, 16'h0001);
      wr(2'd2, 16'h0001);
      bus.pc_in  = 16'h0042;
      bus.irq_in = 8'h01;
      tick;
      rd("e0_ifr", 2'd1, 16'h0001);
      check("e0_n1_ovr", {15'd0, bus.pc_override}, 16'h0000);
      tick;
      check("e0_ovr", {15'd0, bus.pc_override}, 16'h0001);
      check("e0_vec", bus.pc_addr, 16'h0300);
      check("e0_id", {13'd0, bus.irq_id}, 16'h0000);
      tick;
      check("e0_isvc", {15'd0, bus.in_service}, 16'h0001);
      check("e0_svc_ovr", {15'd0, bus.pc_override}, 16'h0000);
      check("e0_svc_pc", bus.pc_addr, 16'h0000);
      rd("e0_ret", 2'd3, 16'h0042);
      rd("e0_ifr_clr", 2'd1, 16'h0000);
      rd("e0_ctrl", 2'd2, 16'h0003);
      end_pulse;
      check("r0_ovr", {15'd0, bus.pc_override}, 16'h0001);
      check("r0_pc", bus.pc_addr, 16'h0042);
      tick;
      check("r0_idle_ovr", {15'd0, bus.pc_override}, 16'h0000);
      check("r0_idle_pc", bus.pc_addr, 16'h0000);
      check("r0_idle_isvc", {15'd0, bus.in_service}, 16'h0000);
      bus.irq_in = 8'h00;
      wr(2'd0, 16'h00FF);

      // simultaneous irq 5 and 2
      bus.irq_in = 8'h24;
      tick;
      rd("p_ifr", 2'd1, 16'h0024);
      tick;
      check("p_vec2", bus.pc_addr, 16'h0308);
      check("p_id2", {13'd0, bus.irq_id}, 16'h0002);
      tick;
      rd("p_ifr_left", 2'd1, 16'h0020);
      check("p_nonest", {15'd0, bus.in_service}, 16'h0001);
      tick;
      check("p_hold", {15'd0, bus.in_service}, 16'h0001);
      end_pulse;
      check("p_ret_ovr", {15'd0, bus.pc_override}, 16'h0001);
      tick;
      check("p_idle_gap", {15'd0, bus.pc_override}, 16'h0000);
      tick;
      check("p_ovr5", {15'd0, bus.pc_override}, 16'h0001);
      check("p_vec5", bus.pc_addr, 16'h0314);
      check("p_id5", {13'd0, bus.irq_id}, 16'h0005);
      tick;
      end_pulse;
      tick;
      check("p_done", {15'd0, bus.in_service}, 16'h0000);
      bus.irq_in = 8'h00;

      // set wins over w1c clear
      wr(2'd2, 16'h0000);
      bus.irq_in = 8'h04;
      wr(2'd1, 16'h0004);
      rd("sw_ifr", 2'd1, 16'h0004);
      wr(2'd1, 16'h0004);
      rd("w1c_ifr", 2'd1, 16'h0000);
      wr(2'd3, 16'hBEEF);
      rd("ret_ro", 2'd3, 16'h0042);
      bus.irq_in = 8'h00;
      tick;

      // GIE gating
      bus.irq_in = 8'h08;
      tick;
      tick;
      rd("g_ifr", 2'd1, 16'h0008);
      check("g_noovr", {15'd0, bus.pc_override}, 16'h0000);
      wr(2'd2, 16'h0001);
      #1;
      check("g_m1", {15'd0, bus.pc_override}, 16'h0000);
      tick;
      check("g_ovr", {15'd0, bus.pc_override}, 16'h0001);
      check("g_vec", bus.pc_addr, 16'h030C);
      tick;
      wr(2'd0, 16'h0000);
      wr(2'd2, 16'h0000);
      #1;
      check("g_noabort", {15'd0, bus.in_service}, 16'h0001);

      // reset during SERVICE
      rst = 1'b0;
      #1;
      check("x_ovr", {15'd0, bus.pc_override}, 16'h0000);
      check("x_isvc", {15'd0, bus.in_service}, 16'h0000);
      rd("x_ret", 2'd3, 16'h0000);
      rd("x_ier", 2'd0, 16'h0000);
      rst = 1'b1;
      end_pulse;
      check("x_end_ovr", {15'd0, bus.pc_override}, 16'h0000);
      check("x_end_isvc", {15'd0, bus.in_service}, 16'h0000);

      // line high through reset must not fire
      wr(2'd0, 16'h00FF);
      wr(2'd2, 16'h0001);
      tick;
      tick;
      rd("a_ifr", 2'd1, 16'h0000);
      check("a_noovr", {15'd0, bus.pc_override}, 16'h0000);
      bus.irq_in = 8'h00;
      tick;
      bus.irq_in = 8'h08;
      tick;
      rd("a_ifr_set", 2'd1, 16'h0008);
      tick;
      check("a_vec", bus.pc_addr, 16'h030C);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL provide parameter N_IRQ, default 8, number of interrupt sources (fixed at 8 for this revision).
REQ-002 SHALL provide parameter VEC_BASE, default 16'h0300, base address of the vector table.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_in  input  8  raw interrupt request lines, synchronous to clk.
REQ-006 SHALL have port pc_in  input  16  current PC value (return-address source).
REQ-007 SHALL have port end_routine  input  1  one-cycle pulse from the controller marking the end of the handler.
REQ-008 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-009 SHALL have port cfg_addr  input  2  register select: 0 IER, 1 IFR, 2 CTRL, 3 RET.
REQ-010 SHALL have port cfg_wdata  input  16  configuration write data.
REQ-011 SHALL have port cfg_rdata  output  16  combinational readback of the register at cfg_addr.
REQ-012 SHALL have port pc_override  output  1  PC mux select; 1 loads pc_addr into the PC.
REQ-013 SHALL have port pc_addr  output  16  override target (vector or return address).
REQ-014 SHALL have port in_service  output  1  high while a handler is executing.
REQ-015 SHALL have port irq_id  output  3  index of the interrupt being serviced.

Function
REQ-016 SHALL detect rising edges on irq_in (prev-sample register) and set the matching IFR bit in the following cycle.
REQ-017 SHALL treat an IFR write as write-1-to-clear; if an edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-018 SHALL make IER (bits 7:0) read/write. CTRL bit0 = GIE, read/write. CTRL bit1 = in_service, read-only. RET is read-only; writes to RET SHALL be ignored.
REQ-019 SHALL define pending = IFR & IER. Highest priority SHALL be the lowest set index.
REQ-020 SHALL implement FSM states IDLE, ENTER, SERVICE and RETURN, with the state held in a register.
REQ-021 IDLE: if GIE=1 and pending is non-zero, SHALL latch the priority index into irq_id and go to ENTER; otherwise SHALL stay in IDLE.
REQ-022 ENTER: for exactly one cycle SHALL drive pc_override=1 and pc_addr=VEC_BASE+(irq_id<<2), capture RET<=pc_in, and clear IFR[irq_id] (a same-cycle new edge on that line still sets it); then SHALL go to SERVICE.
REQ-023 SERVICE: in_service=1. SHALL ignore new pending requests (no nesting). On end_routine=1 SHALL go to RETURN.
REQ-024 RETURN: for exactly one cycle SHALL drive pc_override=1 and pc_addr=RET; then SHALL go to IDLE.
REQ-025 In IDLE and SERVICE, pc_override SHALL be 0 and pc_addr SHALL be 16'h0000.
REQ-026 SHALL ignore end_routine outside SERVICE.
REQ-027 Clearing GIE or IER during SERVICE SHALL NOT abort the handler; it affects only the next IDLE evaluation.
REQ-028 Latency: an edge at cycle N sets IFR at N+1. With GIE and IER enabled, ENTER SHALL occur at N+2 at the earliest.
REQ-029 A request still pending after RETURN SHALL re-enter no earlier than one cycle after IDLE is reached.
REQ-030 All arithmetic SHALL be 16-bit unsigned with wrap-around.

Reset
REQ-031 When rst=0, SHALL asynchronously force: state IDLE; IER, IFR, GIE and RET to 0; irq_id 0; edge registers 0; pc_override 0; in_service 0.
REQ-032 Reset asserted mid-ENTER, mid-SERVICE or mid-RETURN SHALL abandon the handler with no RETURN cycle.
REQ-033 After reset release, lines already high SHALL NOT produce an edge until they go low and then high again.

Verification
REQ-034 IER=8'h01, GIE=1, pc_in=16'h0042, rising edge on irq_in[0] -> pc_override=1 with pc_addr=16'h0300 two cycles later; RET=16'h0042.
REQ-035 Edges on irq_in[5] and irq_in[2] in the same cycle, IER=8'hFF -> irq_id=2 and vector 16'h0308; after RETURN, irq 5 is serviced with vector 16'h0314.
REQ-036 In SERVICE with RET=16'h0042, end_routine pulse -> next cycle pc_override=1 and pc_addr=16'h0042, then IDLE with in_service=0.
REQ-037 IFR write 8'h04 in the same cycle as an irq_in[2] edge -> IFR[2] reads 1.
REQ-038 GIE=0 with an edge on irq_in[3] -> IFR[3]=1 and no override; writing GIE=1 -> ENTER with vector 16'h030C.
REQ-039 rst pulsed low during SERVICE -> immediately pc_override=0, in_service=0 and cfg_rdata at address 3 reads 0; end_routine afterwards has no effect.
